// File: rtl/pd_ctrl_pkg.sv
// Shared types and reset constants for the serial pattern-detector controller.
package pd_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } pd_state_e;

    localparam logic [3:0]  PD_DEF_PATTERN = 4'b1011;
    localparam int unsigned PD_DEF_TARGET  = 1;
    localparam logic        PD_DEF_OVERLAP = 1'b1;

endpackage

// File: rtl/pattern_shift_match.sv
// Serial shift history with fill tracking and a masked compare against the
// next history value, so a hit is known in the same cycle the bit arrives.
module pattern_shift_match #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         shift_i,
    input  logic         in_bit_i,
    input  logic         overlap_i,
    input  logic [W-1:0] pattern_i,
    input  logic [W-1:0] mask_i,
    output logic         hit_o
);

    localparam int FW = $clog2(W + 1);
    localparam logic [FW-1:0] FULL = FW'(W);

    logic [W-1:0]  hist_q, hist_d, hist_nx;
    logic [FW-1:0] fill_q, fill_d, fill_nx;

    assign hist_nx = {hist_q[W-2:0], in_bit_i};
    assign fill_nx = (fill_q == FULL) ? FULL : fill_q + FW'(1);

    assign hit_o = shift_i && (fill_nx == FULL)
                   && (((hist_nx ^ pattern_i) & mask_i) == '0);

    // Non-overlapping mode only needs fill cleared; stale history is gated.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_i) begin
            hist_d = hist_nx;
            fill_d = (hit_o && !overlap_i) ? '0 : fill_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/pattern_detect_ctrl.sv
// Arms, configures and sequences the serial pattern detector; owns the FSM,
// the configuration registers and the match counter.
module pattern_detect_ctrl
    import pd_ctrl_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [W-1:0]     cfg_pattern,
    input  logic [W-1:0]     cfg_mask,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             cfg_overlap,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    localparam logic [W-1:0]     DEF_PAT = W'(PD_DEF_PATTERN);
    localparam logic [CNT_W-1:0] DEF_TGT = CNT_W'(PD_DEF_TARGET);

    pd_state_e        state_q, state_d;
    logic [W-1:0]     pattern_q, pattern_d;
    logic [W-1:0]     mask_q, mask_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic             overlap_q, overlap_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             match_q, match_d;
    logic             err_q, err_d;

    logic start_ok, arm, shift, clr, hit, last;

    // start is meaningless while a run is in progress
    assign start_ok = start && (state_q != ARMED);
    assign arm      = start_ok && (target_q != '0);
    assign shift    = (state_q == ARMED) && in_valid && !abort;
    assign clr      = abort || arm;
    assign last     = hit && ((count_q + CNT_W'(1)) == target_q);

    pattern_shift_match #(.W(W)) u_match (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clr),
        .shift_i   (shift),
        .in_bit_i  (in_bit),
        .overlap_i (overlap_q),
        .pattern_i (pattern_q),
        .mask_i    (mask_q),
        .hit_o     (hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else if (start_ok) begin
            state_d = arm ? ARMED : IDLE;
        end else if ((state_q == ARMED) && last) begin
            state_d = DONE;
        end
    end

    always_comb begin
        pattern_d = pattern_q;
        mask_d    = mask_q;
        target_d  = target_q;
        overlap_d = overlap_q;
        count_d   = count_q;
        match_d   = 1'b0;
        err_d     = 1'b0;
        if (abort) begin
            count_d = count_q;
        end else if (start_ok) begin
            if (arm) begin
                count_d = '0;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            if (cfg_we) begin
                if (state_q == IDLE) begin
                    pattern_d = cfg_pattern;
                    mask_d    = cfg_mask;
                    target_d  = cfg_target;
                    overlap_d = cfg_overlap;
                end else begin
                    err_d = 1'b1;
                end
            end
            if (hit) begin
                match_d = 1'b1;
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= DEF_PAT;
            mask_q    <= '1;
            target_q  <= DEF_TGT;
            overlap_q <= PD_DEF_OVERLAP;
            count_q   <= '0;
            match_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            mask_q    <= mask_d;
            target_q  <= target_d;
            overlap_q <= overlap_d;
            count_q   <= count_d;
            match_q   <= match_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        match       = match_q;
        match_count = count_q;
        busy        = (state_q == ARMED);
        done        = (state_q == DONE);
        cfg_err     = err_q;
    end

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Directed scoreboard bench: stimulus queues expected match/cfg_err events,
// a negedge monitor pops and compares whenever the DUT raises one.
module tb_pattern_detect_ctrl;

    typedef struct {
        logic       m;
        logic       e;
        logic [7:0] cnt;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, cfg_we, cfg_overlap, start, abort, in_valid, in_bit;
    logic [3:0] cfg_pattern, cfg_mask;
    logic [7:0] cfg_target;
    logic       match, busy, done, cfg_err;
    logic [7:0] match_count;

    int   vectors = 0;
    int   errors  = 0;
    exp_t exp_q[$];

    pattern_detect_ctrl #(.W(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_mask    (cfg_mask),
        .cfg_target  (cfg_target),
        .cfg_overlap (cfg_overlap),
        .start       (start),
        .abort       (abort),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .match       (match),
        .match_count (match_count),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (match || cfg_err) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: match=%0b cfg_err=%0b cnt=%0d",
                         match, cfg_err, match_count);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({match, cfg_err, match_count, busy, done} !==
                    {e.m, e.e, e.cnt, e.busy, e.done}) begin
                    errors++;
                    $display("FAIL event: got m=%0b e=%0b cnt=%0d busy=%0b done=%0b, expected m=%0b e=%0b cnt=%0d busy=%0b done=%0b",
                             match, cfg_err, match_count, busy, done,
                             e.m, e.e, e.cnt, e.busy, e.done);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic m, input logic e, input int cnt,
                        input logic b, input logic d);
        exp_t x;
        x.m = m; x.e = e; x.cnt = 8'(cnt); x.busy = b; x.done = d;
        exp_q.push_back(x);
    endtask

    task automatic send_bit(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic send_seq(input logic [15:0] bits, input int n,
                            input logic [15:0] hits, input int cnt0,
                            input int target);
        int c;
        c = cnt0;
        for (int i = n - 1; i >= 0; i--) begin
            if (hits[i]) begin
                c++;
                push(1'b1, 1'b0, c, c != target, c == target);
            end
            send_bit(bits[i]);
        end
    endtask

    task automatic do_cfg(input logic [3:0] p, input logic [3:0] m,
                          input logic [7:0] t, input logic ov);
        cfg_pattern = p;
        cfg_mask    = m;
        cfg_target  = t;
        cfg_overlap = ov;
        cfg_we      = 1'b1;
        tick();
        cfg_we      = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_overlap = 1'b0; start = 1'b0;
        abort = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        cfg_pattern = 4'h0; cfg_mask = 4'h0; cfg_target = 8'd0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_match", match, 0);
        check("rst_count", match_count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", cfg_err, 0);

        // defaults: 1011, full mask, target 1
        do_start();
        check("t1_busy", busy, 1);
        send_seq(16'b1011011, 7, 16'b0001000, 0, 1);
        check("t1_done", done, 1);
        check("t1_count", match_count, 1);

        do_abort();
        check("abort_keeps_count", match_count, 1);
        check("abort_idle", done, 0);
        do_cfg(4'b1011, 4'hF, 8'd3, 1'b1);
        do_start();
        check("t2_count_clr", match_count, 0);
        send_seq(16'b1011011011, 10, 16'b0001001001, 0, 3);
        check("t2_done", done, 1);
        check("t2_count", match_count, 3);

        do_abort();
        do_cfg(4'b1011, 4'hF, 8'd2, 1'b0);
        do_start();
        send_seq(16'b1011011, 7, 16'b0001000, 0, 2);
        check("t3_busy", busy, 1);
        check("t3_count1", match_count, 1);
        send_seq(16'b1011, 4, 16'b0001, 1, 2);
        check("t3_done", done, 1);
        check("t3_count2", match_count, 2);

        do_abort();
        do_cfg(4'b1001, 4'b1001, 8'd1, 1'b1);
        do_start();
        send_seq(16'b1111, 4, 16'b0001, 0, 1);
        check("t4_done", done, 1);
        do_start();
        check("t4_restart_count", match_count, 0);
        check("t4_restart_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) push(1'b1, 1'b0, 1, 1'b0, 1'b1);
            send_bit(1'b1);
            repeat (3) tick();
        end
        check("t4_gap_done", done, 1);
        check("t4_gap_count", match_count, 1);

        // config write while busy must be rejected and leave config intact
        do_abort();
        do_cfg(4'b1011, 4'hF, 8'd2, 1'b1);
        do_start();
        cfg_pattern = 4'b0000;
        cfg_target  = 8'd5;
        cfg_we      = 1'b1;
        push(1'b0, 1'b1, 0, 1'b1, 1'b0);
        tick();
        cfg_we      = 1'b0;
        send_seq(16'b1011, 4, 16'b0001, 0, 2);
        send_seq(16'b011, 3, 16'b001, 1, 2);
        check("t5_done", done, 1);

        do_abort();
        do_cfg(4'b1011, 4'hF, 8'd0, 1'b1);
        start = 1'b1;
        push(1'b0, 1'b1, 2, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        check("t5_tgt0_busy", busy, 0);
        check("t5_tgt0_done", done, 0);

        // abort coincides with the completing bit
        do_cfg(4'b1011, 4'hF, 8'd2, 1'b1);
        do_start();
        send_seq(16'b1011, 4, 16'b0001, 0, 2);
        send_bit(1'b0);
        send_bit(1'b1);
        abort = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        tick();
        abort = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        check("t6_match", match, 0);
        check("t6_count", match_count, 1);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        do_start();
        check("t6_restart_count", match_count, 0);
        check("t6_restart_busy", busy, 1);

        // reset mid-run restores config defaults
        do_abort();
        do_cfg(4'b0110, 4'hF, 8'd3, 1'b1);
        do_start();
        send_seq(16'b0110, 4, 16'b0001, 0, 3);
        check("t7_count", match_count, 1);
        send_bit(1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t7_rst_count", match_count, 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_done", done, 0);
        check("t7_rst_match", match, 0);
        do_start();
        send_seq(16'b1011, 4, 16'b0001, 0, 1);
        check("t7_def_done", done, 1);

        tick();
        tick();
        check("pending_events", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pattern_detect_ctrl.md
Name: pattern_detect_ctrl

Overview:
- Controller that arms, configures and sequences a serial pattern-detector datapath. The datapath is a W-bit shift history compared against a programmable pattern and mask.
- Counts matches, supports overlapping and non-overlapping detection, and signals completion once a programmed number of matches is reached.
- Sits between the configuration/host interface and the serial bit source.

Parameters:
- W, 4, pattern/history width in bits (2..16)
- CNT_W, 8, width of the match counter and target register

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  config write strobe; accepted only in IDLE
- cfg_pattern  in  W  pattern to detect; MSB is the oldest bit
- cfg_mask  in  W  1 = compare this bit position, 0 = don't care
- cfg_target  in  CNT_W  number of matches that ends the run
- cfg_overlap  in  1  1 = overlapping matches, 0 = history restarts after a match
- start  in  1  arm the detector (from IDLE or DONE)
- abort  in  1  return to IDLE from any state
- in_valid  in  1  qualifies in_bit
- in_bit  in  1  serial data bit
- match  out  1  one-cycle pulse per detected match
- match_count  out  CNT_W  matches counted in the current or last run
- busy  out  1  high in ARMED
- done  out  1  high in DONE
- cfg_err  out  1  one-cycle pulse on a rejected command

Behaviour:
- Reset values: state IDLE; pattern = 4'b1011 zero-extended to W; mask all ones; target 1; overlap 1; history 0; fill 0; match 0; match_count 0; busy 0; done 0; cfg_err 0.
- States and transitions:
  - IDLE: start goes to ARMED.
  - ARMED: reaching the target goes to DONE.
  - DONE: start goes to ARMED.
  - abort from any state goes to IDLE.
- Priority: rst > abort > start > cfg_we.
- cfg_we in IDLE: latch all cfg_* fields.
- cfg_we outside IDLE: ignored, and cfg_err pulses on the next cycle.
- start accepted with latched target == 0: stay in or return to IDLE, cfg_err pulses.
- start accepted otherwise: history = 0, fill = 0, match_count = 0, then enter ARMED.
- ARMED, cycle with in_valid = 1:
  - hist_next = {history[W-2:0], in_bit}
  - fill saturates at W
  - hit = (fill_next == W) && (((hist_next ^ pattern) & mask) == 0)
- Cycles with in_valid = 0: no shift, no change.
- Latency: a bit sampled at edge N produces match = 1 during the cycle following edge N (one register stage). match_count updates in that same cycle.
- On hit:
  - match_count increments.
  - If overlap = 0, fill is cleared; history may keep its contents because fill gates comparison.
  - If overlap = 1, fill stays W.
- Hit where match_count + 1 == target: enter DONE in the same edge. done rises in the same cycle as the final match pulse.
- The counter cannot wrap because the run ends at the target.
- in_valid in IDLE or DONE: ignored.
- DONE: done = 1 and match_count is held until start or abort.
- abort: history and fill are cleared. match_count is retained for readback and is cleared only by start.
- abort and a hit on the same edge: abort wins, no match pulse, count unchanged.
- start in ARMED: ignored, no error (busy run continues).
- rst mid-run: everything returns to reset values on the next edge, including the config registers.

Decomposition:
- Package pd_ctrl_pkg:
  - state enum {IDLE, ARMED, DONE}
  - reset constants: PD_DEF_PATTERN = 4'b1011, PD_DEF_TARGET = 1, PD_DEF_OVERLAP = 1
- Sub-module pattern_shift_match (W):
  - Holds history and fill, with shift/clear controls.
  - Outputs combinational hit against pattern/mask.
  - The controller owns the FSM, the config registers and the counter.

Test Plan:
- Reset defaults, start, stream 1,0,1,1,0,1,1 with in_valid every cycle -> match pulses after bits 4 and 7. Target 1 -> done after bit 4, match_count = 1, later bits ignored.
- cfg pattern 1011, target 3, overlap 1; stream 1011011011 -> matches after bits 4, 7, 10. done with the third pulse, count = 3.
- Same config with overlap 0, target 2, stream 1011011 -> only one match (bit 4), still busy. Then stream 1011 -> second match, done, count = 2.
- mask 4'b1001, pattern 4'b1001, stream 1111 -> match after bit 4. in_valid gaps of 3 idle cycles between bits -> same result, no extra pulses.
- Error paths:
  - cfg_we while busy -> cfg_err pulse, config unchanged.
  - target 0 plus start -> cfg_err, stays IDLE.
- abort on the same edge as a completing bit -> no match, count unchanged, IDLE. Then start -> count 0.
- rst asserted mid-run -> all outputs at reset values next cycle, pattern back to 1011.
